// File: rtl/dvi_video_timing_gen.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dvi_video_timing_gen                                                    |
// | Raster timing and test-pattern source for the DVI output path.          |
// | VTG_PATTERN_EN compiles in the pattern generator; otherwise flat colour.|
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module dvi_video_timing_gen #(
  parameter int         H_ACTIVE = 640,
  parameter int         H_FP     = 16,
  parameter int         H_SYNC   = 96,
  parameter int         H_BP     = 48,
  parameter int         V_ACTIVE = 480,
  parameter int         V_FP     = 10,
  parameter int         V_SYNC   = 2,
  parameter int         V_BP     = 33,
  parameter bit         SYNC_POL = 1'b1,
  parameter logic [7:0] FLAT_R   = 8'd145,
  parameter logic [7:0] FLAT_G   = 8'd200,
  parameter logic [7:0] FLAT_B   = 8'd100
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  input  logic [1:0]  pattern_sel,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [12:0] x,
  output logic [12:0] y,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);
  localparam logic [12:0] c_h_last = 13'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [12:0] c_v_last = 13'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [12:0] c_h_act  = 13'(H_ACTIVE);
  localparam logic [12:0] c_v_act  = 13'(V_ACTIVE);
  localparam logic [12:0] c_hs_beg = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] c_hs_end = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] c_vs_beg = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] c_vs_end = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [12:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;
  logic [12:0] x_q, x_d, y_q, y_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic        w_h_last, w_v_last, w_active, w_first;
  logic [7:0]  w_pix_r, w_pix_g, w_pix_b;

  assign w_h_last = (h_cnt_q == c_h_last);
  assign w_v_last = (v_cnt_q == c_v_last);
  assign w_active = (h_cnt_q < c_h_act) && (v_cnt_q < c_v_act);
  assign w_first  = (h_cnt_q == 13'd0) && (v_cnt_q == 13'd0);

  always_comb begin
    h_cnt_d = w_h_last ? 13'd0 : h_cnt_q + 13'd1;
    v_cnt_d = v_cnt_q;
    if (w_h_last) begin
      v_cnt_d = w_v_last ? 13'd0 : v_cnt_q + 13'd1;
    end
    de_d          = w_active;
    hsync_d       = ((h_cnt_q >= c_hs_beg) && (h_cnt_q < c_hs_end)) ? SYNC_POL : ~SYNC_POL;
    // v_cnt only moves on the line wrap, so vsync is inherently line-aligned
    vsync_d       = ((v_cnt_q >= c_vs_beg) && (v_cnt_q < c_vs_end)) ? SYNC_POL : ~SYNC_POL;
    frame_start_d = w_first;
    x_d           = w_active ? h_cnt_q : 13'd0;
    y_d           = w_active ? v_cnt_q : 13'd0;
    r_d           = w_active ? w_pix_r : 8'd0;
    g_d           = w_active ? w_pix_g : 8'd0;
    b_d           = w_active ? w_pix_b : 8'd0;
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= 13'd0;
      v_cnt_q       <= 13'd0;
      de_q          <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
      x_q           <= 13'd0;
      y_q           <= 13'd0;
      r_q           <= 8'd0;
      g_q           <= 8'd0;
      b_q           <= 8'd0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      x_q           <= x_d;
      y_q           <= y_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

`ifdef VTG_PATTERN_EN
  localparam logic [12:0] c_bar_last = 13'(H_ACTIVE / 8 - 1);

  logic [1:0]  pat_q, pat_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [12:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [12:0] w_mb_lo, w_mb_hi;
  logic        w_mb_on;

  always_comb begin
    // The first pixel of a frame already uses the request being latched.
    pat_d       = w_first ? pattern_sel : pat_q;
    frame_cnt_d = (w_h_last && w_v_last) ? frame_cnt_q + 8'd1 : frame_cnt_q;
    bar_cnt_d   = bar_cnt_q + 13'd1;
    bar_idx_d   = bar_idx_q;
    if (w_h_last) begin
      bar_cnt_d = 13'd0;
      bar_idx_d = 3'd0;
    end else if (bar_cnt_q == c_bar_last) begin
      bar_cnt_d = 13'd0;
      bar_idx_d = bar_idx_q + 3'd1;
    end
    w_mb_lo = {4'd0, frame_cnt_q, 1'b0};
    w_mb_hi = w_mb_lo + 13'd16;
    w_mb_on = (h_cnt_q >= w_mb_lo) && (h_cnt_q < w_mb_hi);
    w_pix_r = 8'd0;
    w_pix_g = 8'd0;
    w_pix_b = 8'd0;
    case (pat_d)
      // Bar order W,Y,C,G,M,R,B,K decodes straight from the index bits.
      2'd0: begin
        w_pix_r = {8{~bar_idx_q[1]}};
        w_pix_g = {8{~bar_idx_q[2]}};
        w_pix_b = {8{~bar_idx_q[0]}};
      end
      2'd1: begin
        w_pix_r = h_cnt_q[7:0];
        w_pix_g = h_cnt_q[7:0];
        w_pix_b = h_cnt_q[7:0];
      end
      2'd2: begin
        w_pix_r = {8{h_cnt_q[3] ^ v_cnt_q[3]}};
        w_pix_g = {8{h_cnt_q[3] ^ v_cnt_q[3]}};
        w_pix_b = {8{h_cnt_q[3] ^ v_cnt_q[3]}};
      end
      default: begin
        w_pix_r = {8{w_mb_on}};
        w_pix_g = {8{w_mb_on}};
        w_pix_b = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q       <= 2'd0;
      frame_cnt_q <= 8'd0;
      bar_cnt_q   <= 13'd0;
      bar_idx_q   <= 3'd0;
    end else begin
      pat_q       <= pat_d;
      frame_cnt_q <= frame_cnt_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
    end
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = ^pattern_sel;
  assign w_pix_r = FLAT_R;
  assign w_pix_g = FLAT_G;
  assign w_pix_b = FLAT_B;
`endif

  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign x           = x_q;
  assign y           = y_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
endmodule
`default_nettype wire

// File: tb/tb_dvi_video_timing_gen.sv
`default_nettype none
// Bench for dvi_video_timing_gen on a reduced 80x23 raster (64x16 active) so
// whole frames fit in a short run; expectations follow the VTG_PATTERN_EN build.
module tb_dvi_video_timing_gen;
  localparam int F_CYC = 1840;

`ifdef VTG_PATTERN_EN
  localparam int E_WHITE  = 32'h00FFFFFF;
  localparam int E_YELLOW = 32'h00FFFF00;
  localparam int E_BLACK  = 32'h00000000;
  localparam int E_RAMP37 = 32'h00252525;
  localparam int E_BLUE   = 32'h000000FF;
`else
  localparam int E_WHITE  = 32'h0091C864;
  localparam int E_YELLOW = 32'h0091C864;
  localparam int E_BLACK  = 32'h0091C864;
  localparam int E_RAMP37 = 32'h0091C864;
  localparam int E_BLUE   = 32'h0091C864;
`endif

  logic        pix_clk, rst_n;
  logic [1:0]  pattern_sel;
  logic        de, hsync, vsync, frame_start;
  logic [12:0] x, y;
  logic [7:0]  r, g, b;
  logic [31:0] rgb;
  assign rgb = {8'h00, r, g, b};

  int n_tot = 0, n_bad = 0, pix = -1;
  int de_n = 0, hs_n = 0, hs_first = -1;
  int fs_n = 0, fs_at = -1, vs_n = 0, vs_first = -1, de_f = 0;
  logic [31:0] fs_rgb = 32'd0;

  dvi_video_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1), .FLAT_R(8'd145), .FLAT_G(8'd200), .FLAT_B(8'd100)
  ) dut (
    .pix_clk(pix_clk), .rst_n(rst_n), .pattern_sel(pattern_sel),
    .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
    .x(x), .y(y), .r(r), .g(g), .b(b)
  );

  initial pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pix_clk);
    #1;
    pix++;
  endtask

  task automatic goto(input int p);
    while (pix < p) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    pattern_sel = 2'd0;
    #2 rst_n = 1'b0;
    repeat (5) @(negedge pix_clk);
    chk("rst_de", 32'(de), 0);
    chk("rst_hsync", 32'(hsync), 0);
    chk("rst_vsync", 32'(vsync), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_x", 32'(x), 0);

    rst_n = 1'b1;
    step();
    chk("p0_de", 32'(de), 1);
    chk("p0_fs", 32'(frame_start), 1);
    chk("p0_x", 32'(x), 0);
    chk("p0_y", 32'(y), 0);
    chk("p0_rgb", rgb, E_WHITE);

    // Line 0: pixels 0..79
    for (int i = 0; i < 80; i++) begin
      if (i > 0) step();
      if (de) de_n++;
      if (hsync) begin
        hs_n++;
        if (hs_first < 0) hs_first = pix;
      end
      if (pix == 1) chk("p1_fs", 32'(frame_start), 0);
      if (pix == 8) chk("bar_x8", rgb, E_YELLOW);
      if (pix == 63) begin
        chk("bar_x63", rgb, E_BLACK);
        chk("x63", 32'(x), 63);
      end
      if (pix == 70) begin
        chk("hblank_rgb", rgb, 0);
        chk("hblank_x", 32'(x), 0);
      end
    end
    chk("line_de_cnt", de_n, 64);
    chk("line_hs_cnt", hs_n, 8);
    chk("line_hs_first", hs_first, 68);

    // Rest of frame 0 plus line 0 of frame 1
    for (int i = 0; i < F_CYC; i++) begin
      step();
      if (frame_start) begin
        fs_n++;
        fs_at = pix;
        fs_rgb = rgb;
      end
      if (vsync) begin
        vs_n++;
        if (vs_first < 0) vs_first = pix;
      end
      if (de) de_f++;
      if (pix == 80) begin
        chk("line1_de", 32'(de), 1);
        chk("line1_y", 32'(y), 1);
      end
    end
    chk("frame_fs_cnt", fs_n, 1);
    chk("frame_fs_at", fs_at, F_CYC);
    chk("frame_fs_rgb", fs_rgb, E_WHITE);
    chk("frame_vs_cnt", vs_n, 160);
    chk("frame_vs_first", vs_first, 1440);
    chk("frame_de_cnt", de_f, 1024);

    // Request checkerboard mid-frame 1: frame 1 stays bars
    goto(2248);
    pattern_sel = 2'd2;
    chk("f1_keep_bars", rgb, E_YELLOW);
    goto(3688);
    chk("f2_chk_8_0", rgb, E_WHITE);
    goto(4328);
    chk("f2_chk_8_8", rgb, E_BLACK);
    pattern_sel = 2'd1;
    goto(5797);
    chk("f3_ramp_37", rgb, E_RAMP37);
    pattern_sel = 2'd3;
    // Frame 4: frame_cnt=4, bar spans x 8..23
    goto(7367);
    chk("mb_x7", rgb, E_BLUE);
    goto(7368);
    chk("mb_x8", rgb, E_WHITE);
    goto(7383);
    chk("mb_x23", rgb, E_WHITE);
    goto(7384);
    chk("mb_x24", rgb, E_BLUE);

    // Asynchronous reset in the middle of an active line
    goto(7550);
    chk("pre_rst_de", 32'(de), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_de", 32'(de), 0);
    chk("async_rgb", rgb, 0);
    chk("async_x", 32'(x), 0);
    repeat (3) @(negedge pix_clk);
    chk("rst2_fs", 32'(frame_start), 0);
    rst_n = 1'b1;
    pix = -1;
    step();
    chk("re_de", 32'(de), 1);
    chk("re_fs", 32'(frame_start), 1);
    chk("re_x", 32'(x), 0);
    chk("re_y", 32'(y), 0);
    chk("re_rgb", rgb, E_WHITE);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
